// File: rtl/tour_ctrl.sv
// tour_ctrl: decodes the tour command, runs the solver, counts move handshakes and reports a status byte.
module tour_ctrl #(
  parameter int SOLVE_TIMEOUT = 1048576,
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic        go,
  output logic [2:0]  x_start,
  output logic [2:0]  y_start,
  input  logic        tour_done,
  output logic        start_tour,
  input  logic        send_resp,
  output logic        tour_active,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done
);
  localparam int TW = $clog2(SOLVE_TIMEOUT);
  typedef enum logic [1:0] {IDLE, SOLVE, RUN, REPORT} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [5:0] resp_cnt, resp_cnt_n;
  logic [2:0] x_n, y_n;
  logic [7:0] tx_n;
  logic go_n, clr_n, st_n, trmt_n, active_n, tour_cmd;
  assign tour_cmd = cmd_rdy_UART && cmd_UART[15:12] == 4'h6;
  always_comb begin
    state_n = state;
    timer_n = timer;
    resp_cnt_n = resp_cnt;
    x_n = x_start;
    y_n = y_start;
    tx_n = tx_data;
    go_n = 1'b0;
    st_n = 1'b0;
    trmt_n = 1'b0;
    // A held command level is consumed on alternate cycles so clr never stretches.
    clr_n = tour_cmd && !clr_cmd_rdy_UART;
    case (state)
      IDLE: if (clr_n) begin
        state_n = SOLVE;
        go_n = 1'b1;
        x_n = cmd_UART[6:4];
        y_n = cmd_UART[2:0];
        timer_n = '0;
      end
      SOLVE: if (tour_done) begin
        state_n = RUN;
        st_n = 1'b1;
        resp_cnt_n = '0;
      end else if (timer == TW'(SOLVE_TIMEOUT - 1)) begin
        state_n = REPORT;
        tx_n = 8'hEE;
        trmt_n = 1'b1;
      end else timer_n = timer + 1'b1;
      RUN: if (send_resp) begin
        resp_cnt_n = &resp_cnt ? resp_cnt : resp_cnt + 6'd1;
        if ({1'b0, resp_cnt} + 7'd1 == 7'(2 * NUM_MOVES)) begin
          state_n = REPORT;
          tx_n = 8'hA5;
          trmt_n = 1'b1;
        end
      end
      REPORT: if (tx_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    active_n = state_n == SOLVE || state_n == RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      resp_cnt <= '0;
      x_start <= '0;
      y_start <= '0;
      tx_data <= '0;
      go <= 1'b0;
      clr_cmd_rdy_UART <= 1'b0;
      start_tour <= 1'b0;
      trmt <= 1'b0;
      tour_active <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      resp_cnt <= resp_cnt_n;
      x_start <= x_n;
      y_start <= y_n;
      tx_data <= tx_n;
      go <= go_n;
      clr_cmd_rdy_UART <= clr_n;
      start_tour <= st_n;
      trmt <= trmt_n;
      tour_active <= active_n;
    end
endmodule

// File: tb/tb_tour_ctrl.sv
// tb_tour_ctrl: randomized self-checking bench for tour_ctrl with a timing-level reference model.
module tb_tour_ctrl;
  localparam int TO = 64;
  localparam int NRESP = 48;
  logic clk = 0, rst = 1;
  logic [15:0] cmd_UART = '0;
  logic cmd_rdy_UART = 0, tour_done = 0, send_resp = 0, tx_done = 0;
  logic clr_cmd_rdy_UART, go, start_tour, tour_active, trmt;
  logic [2:0] x_start, y_start;
  logic [7:0] tx_data;
  tour_ctrl #(.SOLVE_TIMEOUT(TO), .NUM_MOVES(24)) dut (
    .clk(clk), .rst(rst), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .go(go), .x_start(x_start), .y_start(y_start),
    .tour_done(tour_done), .start_tour(start_tour), .send_resp(send_resp),
    .tour_active(tour_active), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  int go_cnt = 0, st_cnt = 0, trmt_cnt = 0, clr_cnt = 0, go_t = 0, st_t = 0, trmt_t = 0;
  logic [7:0] trmt_byte = '0;
  logic [3:0] prev = '0;
  // Pulse bookkeeping; tasks read these #1 after the same negedge.
  always @(negedge clk) begin
    if (go) begin go_cnt++; go_t = cyc; end
    if (start_tour) begin st_cnt++; st_t = cyc; end
    if (trmt) begin trmt_cnt++; trmt_t = cyc; trmt_byte = tx_data; end
    if (clr_cmd_rdy_UART) clr_cnt++;
    checks++;
    if (({go, start_tour, trmt, clr_cmd_rdy_UART} & prev) !== 4'b0) begin
      errors++;
      $display("FAIL pulse_width got=%b prev=%b at cyc %0d", {go, start_tour, trmt, clr_cmd_rdy_UART}, prev, cyc);
    end
    prev = {go, start_tour, trmt, clr_cmd_rdy_UART};
  end
  function automatic logic [15:0] mk(input logic [2:0] x, input logic [2:0] y);
    return {4'h6, 5'h0, x, 1'b0, y};
  endfunction
  // Outcome of a tour whose tour_done is sampled d edges after the go edge.
  function automatic logic [7:0] model_status(input int d);
    return d <= TO ? 8'hA5 : 8'hEE;
  endfunction
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic issue_cmd(input logic [15:0] c, input int hold);
    int c0;
    c0 = clr_cnt;
    cmd_UART = c;
    cmd_rdy_UART = 1;
    for (int i = 0; i < hold && clr_cnt == c0; i++) tick(1);
    cmd_rdy_UART = 0;
  endtask
  task automatic pulse_done();
    tour_done = 1; tick(1); tour_done = 0;
  endtask
  task automatic ack_tx();
    tick(3); tx_done = 1; tick(1); tx_done = 0;
  endtask
  task automatic test_reset();
    rst = 1; cmd_rdy_UART = 1; cmd_UART = 16'h6023;
    tick(3);
    checks++;
    if ({go, clr_cmd_rdy_UART, start_tour, trmt, tour_active, tx_data, x_start, y_start} !== 19'b0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {go, clr_cmd_rdy_UART, start_tour, trmt, tour_active, tx_data, x_start, y_start});
    end
    rst = 0;
    tick(1);
    cmd_rdy_UART = 0;
    checks++;
    if ({go, clr_cmd_rdy_UART, x_start, y_start, tour_active} !== {1'b1, 1'b1, 3'd2, 3'd3, 1'b1}) begin
      errors++; $display("FAIL reset_accept got=%b want=%b", {go, clr_cmd_rdy_UART, x_start, y_start, tour_active}, {1'b1, 1'b1, 3'd2, 3'd3, 1'b1});
    end
    for (int i = 0; i < 80 && trmt_cnt == 0; i++) tick(1);
    checks++;
    if (trmt_byte !== 8'hEE) begin errors++; $display("FAIL reset_cleanup got=%h want=ee", trmt_byte); end
    ack_tx();
  endtask
  task automatic test_full_tour();
    logic [2:0] x, y;
    int g0, s0, t0, c0, g;
    x = 3'($urandom); y = 3'($urandom);
    g0 = go_cnt; s0 = st_cnt; t0 = trmt_cnt;
    issue_cmd(mk(x, y), 4);
    g = go_t;
    checks++;
    if (go_cnt !== g0 + 1 || x_start !== x || y_start !== y) begin
      errors++; $display("FAIL full_accept got go=%0d x=%0d y=%0d want go=%0d x=%0d y=%0d", go_cnt, x_start, y_start, g0 + 1, x, y);
    end
    tick(9);
    pulse_done();
    checks++;
    if (st_cnt !== s0 + 1 || st_t !== g + 10) begin
      errors++; $display("FAIL full_start got cnt=%0d t=%0d want cnt=%0d t=%0d", st_cnt, st_t, s0 + 1, g + 10);
    end
    for (int i = 0; i < NRESP; i++) begin
      send_resp = 1; tick(1); send_resp = 0;
      if (i == 10) begin
        c0 = clr_cnt; g0 = go_cnt;
        issue_cmd(16'h2BEA, 3);
        checks++;
        if (clr_cnt !== c0 || go_cnt !== g0 || tour_active !== 1'b1) begin
          errors++; $display("FAIL pass_run got clr=%0d go=%0d act=%b want clr=%0d go=%0d act=1", clr_cnt, go_cnt, tour_active, c0, g0);
        end
      end
      if (i == 20) begin
        c0 = clr_cnt;
        issue_cmd(16'h6077, 4);
        checks++;
        if (clr_cnt !== c0 + 1 || x_start !== x || y_start !== y) begin
          errors++; $display("FAIL collide_cmd got clr=%0d x=%0d y=%0d want clr=%0d x=%0d y=%0d", clr_cnt, x_start, y_start, c0 + 1, x, y);
        end
      end
      if (i == NRESP - 2) begin
        checks++;
        if (trmt_cnt !== t0) begin errors++; $display("FAIL full_early got trmt=%0d want %0d", trmt_cnt, t0); end
      end
      if (i < NRESP - 1) tick(99);
    end
    checks++;
    if (trmt_cnt !== t0 + 1 || trmt_t !== cyc || trmt_byte !== 8'hA5) begin
      errors++; $display("FAIL full_report got cnt=%0d t=%0d byte=%h want cnt=%0d t=%0d byte=a5", trmt_cnt, trmt_t, trmt_byte, t0 + 1, cyc);
    end
    ack_tx();
    checks++;
    if (tour_active !== 1'b0 || st_cnt !== s0 + 1) begin
      errors++; $display("FAIL full_end got act=%b st=%0d want act=0 st=%0d", tour_active, st_cnt, s0 + 1);
    end
  endtask
  task automatic test_timeout();
    int s0, t0, g;
    s0 = st_cnt; t0 = trmt_cnt;
    issue_cmd(16'h6000, 4);
    g = go_t;
    for (int i = 0; i < 80 && trmt_cnt == t0; i++) tick(1);
    checks++;
    if (trmt_cnt !== t0 + 1 || trmt_t - g !== TO || trmt_byte !== 8'hEE || st_cnt !== s0) begin
      errors++; $display("FAIL timeout got cnt=%0d dt=%0d byte=%h st=%0d want cnt=%0d dt=%0d byte=ee st=%0d", trmt_cnt, trmt_t - g, trmt_byte, st_cnt, t0 + 1, TO, s0);
    end
    ack_tx();
  endtask
  task automatic test_collision();
    int s0, t0, g;
    s0 = st_cnt; t0 = trmt_cnt;
    issue_cmd(mk(3'($urandom), 3'($urandom)), 4);
    g = go_t;
    tick(TO - 1);
    pulse_done();
    tick(3);
    checks++;
    if (st_cnt !== s0 + 1 || st_t !== g + TO || trmt_cnt !== t0) begin
      errors++; $display("FAIL collide_done got st=%0d t=%0d trmt=%0d want st=%0d t=%0d trmt=%0d", st_cnt, st_t, trmt_cnt, s0 + 1, g + TO, t0);
    end
    for (int i = 0; i < NRESP; i++) begin send_resp = 1; tick(1); send_resp = 0; tick($urandom_range(0, 2)); end
    checks++;
    if (trmt_cnt !== t0 + 1 || trmt_byte !== 8'hA5) begin
      errors++; $display("FAIL collide_report got cnt=%0d byte=%h want cnt=%0d byte=a5", trmt_cnt, trmt_byte, t0 + 1);
    end
    ack_tx();
  endtask
  task automatic test_passthrough();
    int c0, g0;
    c0 = clr_cnt; g0 = go_cnt;
    issue_cmd(16'h2BEA, 3);
    tick(2);
    checks++;
    if (clr_cnt !== c0 || go_cnt !== g0 || tour_active !== 1'b0) begin
      errors++; $display("FAIL pass_idle got clr=%0d go=%0d act=%b want clr=%0d go=%0d act=0", clr_cnt, go_cnt, tour_active, c0, g0);
    end
  endtask
  task automatic test_rst_mid();
    int t0;
    issue_cmd(mk(3'd5, 3'd1), 4);
    tick(2); pulse_done();
    for (int i = 0; i < 20; i++) begin send_resp = 1; tick(1); send_resp = 0; tick(1); end
    rst = 1; #1;
    checks++;
    if ({go, clr_cmd_rdy_UART, start_tour, trmt, tour_active, tx_data, x_start, y_start} !== 19'b0) begin
      errors++; $display("FAIL rst_mid got=%h want=0", {go, clr_cmd_rdy_UART, start_tour, trmt, tour_active, tx_data, x_start, y_start});
    end
    tick(1); rst = 0; tick(1);
    t0 = trmt_cnt;
    issue_cmd(mk(3'd6, 3'd4), 4);
    tick(1); pulse_done();
    for (int i = 0; i < NRESP - 1; i++) begin send_resp = 1; tick(1); send_resp = 0; tick(1); end
    checks++;
    if (trmt_cnt !== t0) begin errors++; $display("FAIL rst_cnt_early got trmt=%0d want %0d", trmt_cnt, t0); end
    send_resp = 1; tick(1); send_resp = 0;
    checks++;
    if (trmt_cnt !== t0 + 1 || trmt_byte !== 8'hA5) begin
      errors++; $display("FAIL rst_cnt_full got cnt=%0d byte=%h want cnt=%0d byte=a5", trmt_cnt, trmt_byte, t0 + 1);
    end
    ack_tx();
  endtask
  task automatic test_random_tours();
    logic [2:0] x, y;
    int d, g, s0, t0, last;
    for (int n = 0; n < 8; n++) begin
      x = 3'($urandom); y = 3'($urandom);
      d = (n == 0) ? TO : (n == 1) ? TO + 1 : $urandom_range(1, 80);
      s0 = st_cnt; t0 = trmt_cnt;
      issue_cmd(mk(x, y), 4);
      g = go_t;
      checks++;
      if (x_start !== x || y_start !== y || tour_active !== 1'b1) begin
        errors++; $display("FAIL rand_accept got x=%0d y=%0d act=%b want x=%0d y=%0d act=1", x_start, y_start, tour_active, x, y);
      end
      tick(d - 1);
      pulse_done();
      last = cyc;
      if (model_status(d) == 8'hA5) begin
        for (int i = 0; i < NRESP; i++) begin
          tick($urandom_range(0, 2));
          send_resp = 1; tick(1); send_resp = 0; last = cyc;
        end
      end
      tick(1);
      checks++;
      if (trmt_cnt !== t0 + 1 || trmt_byte !== model_status(d)
          || trmt_t !== (model_status(d) == 8'hA5 ? last : g + TO)
          || st_cnt !== s0 + (model_status(d) == 8'hA5 ? 1 : 0)) begin
        errors++; $display("FAIL rand_tour d=%0d got cnt=%0d byte=%h t=%0d st=%0d want cnt=%0d byte=%h", d, trmt_cnt, trmt_byte, trmt_t - g, st_cnt - s0, t0 + 1, model_status(d));
      end
      ack_tx();
    end
  endtask
  initial begin
    test_reset();
    test_full_tour();
    test_timeout();
    test_collision();
    test_passthrough();
    test_rst_mid();
    test_random_tours();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
